// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the reset controller: FSM encoding, memory-map words
// and CAUSE register bit positions.
package reset_ctrl_pkg;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [1:0] ADDR_CAUSE = 2'b00;
   localparam logic [1:0] ADDR_COUNT = 2'b01;

   localparam int CAUSE_POR = 0;
   localparam int CAUSE_WDT = 1;
   localparam int CAUSE_SW  = 2;
   localparam int CAUSE_EXT = 3;

   localparam int SW_RST_BIT = 15;

   localparam logic [3:0] CAUSE_AT_POR = 4'b0001;

endpackage

// File: rtl/reset_ctrl_btn_debounce.sv
// Two-flop synchronizer plus level debouncer for the external reset button;
// o_press pulses for one cycle when the debounced level rises.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

   logic       sync1_q, sync2_q;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic [3:0] cnt_q, cnt_d;

   // cnt_q counts consecutive synchronized samples that disagree with the level
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = 4'd0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;
   assign o_press = press_q;

endmodule

// File: rtl/reset_ctrl.sv
// Processor reset sequencer: holds o_sysRstn low for HOLD_CYCLES after any
// reset trigger and records the causes in a small memory-mapped register file.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_HOLD | o_sysRstn low, hold counter running
//   ST_RUN  | o_sysRstn high, waiting for a trigger
module reset_ctrl
   import reset_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES     = 16,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_memAddr,
   input  logic [15:0] i_memDataIn,
   input  logic        i_memWrEn,
   output logic [15:0] o_memDataOut,
   input  logic        i_wdReset,
   input  logic        i_extBtn,
   output logic        o_sysRstn
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] count_q, count_d;
   logic [3:0] cause_q, cause_d;

   logic ext_level, ext_press, ext_trig;
   logic wr_cause, wr_count, sw_req, trigger;
   logic unused_data;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (i_extBtn),
      .o_level(ext_level),
      .o_press(ext_press)
   );

   // the press pulse coincides with the level going high; qualifying keeps the two coherent
   assign ext_trig = ext_press & ext_level;

   assign wr_cause    = i_memWrEn && (i_memAddr == ADDR_CAUSE);
   assign wr_count    = i_memWrEn && (i_memAddr == ADDR_COUNT);
   assign sw_req      = wr_cause && i_memDataIn[SW_RST_BIT];
   assign trigger     = i_wdReset | sw_req | ext_trig;
   assign unused_data = ^i_memDataIn[14:4];

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (trigger) begin
         state_d    = ST_HOLD;
         hold_cnt_d = 8'd0;
      end else if (state_q == ST_HOLD) begin
         if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
         end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
         end
      end
   end

   // clears are applied before sets so a same-cycle set wins
   always_comb begin
      cause_d = cause_q;
      if (wr_cause) begin
         cause_d = cause_q & ~i_memDataIn[3:0];
      end
      if (i_wdReset) cause_d[CAUSE_WDT] = 1'b1;
      if (sw_req)    cause_d[CAUSE_SW]  = 1'b1;
      if (ext_trig)  cause_d[CAUSE_EXT] = 1'b1;

      count_d = count_q;
      if (wr_count) begin
         count_d = 8'd0;
      end else if (trigger && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= 8'd0;
         cause_q    <= CAUSE_AT_POR;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      o_memDataOut = 16'h0000;
      case (i_memAddr)
         ADDR_CAUSE: o_memDataOut = {12'b0, cause_q};
         ADDR_COUNT: o_memDataOut = {7'b0, (state_q == ST_HOLD), count_q};
         default:    o_memDataOut = 16'h0000;
      endcase
   end

   assign o_sysRstn = (state_q == ST_RUN);

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: directed sequences, a vector table and
// randomized traffic against a cycle-level behavioural model.
module tb_reset_ctrl;

   localparam int H = 16;
   localparam int D = 8;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [1:0]  i_memAddr;
   logic [15:0] i_memDataIn;
   logic        i_memWrEn;
   logic [15:0] o_memDataOut;
   logic        i_wdReset;
   logic        i_extBtn;
   logic        o_sysRstn;

   always #5 i_clk = ~i_clk;

   reset_ctrl #(.HOLD_CYCLES(H), .DEBOUNCE_CYCLES(D)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_memAddr   (i_memAddr),
      .i_memDataIn (i_memDataIn),
      .i_memWrEn   (i_memWrEn),
      .o_memDataOut(o_memDataOut),
      .i_wdReset   (i_wdReset),
      .i_extBtn    (i_extBtn),
      .o_sysRstn   (o_sysRstn)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rd(input string name, input logic [1:0] a, input logic [15:0] exp);
      i_memAddr = a;
      #1;
      check(name, o_memDataOut, exp);
   endtask

   task automatic idle();
      i_memWrEn   = 1'b0;
      i_wdReset   = 1'b0;
      i_memDataIn = 16'h0000;
   endtask

   task automatic write(input logic [1:0] a, input logic [15:0] d);
      i_memAddr   = a;
      i_memDataIn = d;
      i_memWrEn   = 1'b1;
      @(negedge i_clk);
      idle();
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      idle();
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // counts low samples from the current negedge until o_sysRstn rises
   task automatic count_low(output int n);
      n = 0;
      for (int k = 0; k < 400 && o_sysRstn == 1'b0; k++) begin
         n++;
         @(negedge i_clk);
      end
      if (o_sysRstn == 1'b0) begin
         total++;
         bad++;
         $display("FAIL low_timeout: o_sysRstn still %b, required 1", o_sysRstn);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0]   m_cause;
   int           m_count;
   int           m_low;        // low cycles still to be observed
   logic         m_level;
   logic         m_press;
   logic [1:0]   m_dly;        // [0]=first sync stage, [1]=second
   logic [D-1:0] m_hist;       // last D synchronized samples

   task automatic m_reset();
      m_cause = 4'b0001;
      m_count = 0;
      m_low   = H;
      m_level = 1'b0;
      m_press = 1'b0;
      m_dly   = 2'b00;
      m_hist  = '0;
   endtask

   function automatic logic [15:0] m_read(input logic [1:0] a);
      logic [7:0] c8;
      c8 = 8'(m_count);
      case (a)
         2'd0:    return {12'b0, m_cause};
         2'd1:    return {7'b0, (m_low > 0), c8};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic m_step(input logic rst, input logic wr, input logic [1:0] a,
                         input logic [15:0] d, input logic wd, input logic btn);
      logic sw, trig, np;
      if (rst) begin
         m_reset();
      end else begin
         sw   = wr && (a == 2'd0) && d[15];
         trig = wd || sw || m_press;
         if (wr && a == 2'd0) m_cause = m_cause & ~d[3:0];
         if (wd)      m_cause[1] = 1'b1;
         if (sw)      m_cause[2] = 1'b1;
         if (m_press) m_cause[3] = 1'b1;
         if (wr && a == 2'd1) m_count = 0;
         else if (trig && m_count < 255) m_count++;
         if (trig) m_low = H;
         else if (m_low > 0) m_low--;
         np     = 1'b0;
         m_hist = {m_hist[D-2:0], m_dly[1]};
         if (m_hist == {D{~m_level}}) begin
            m_level = ~m_level;
            np      = m_level;
         end
         m_press = np;
         m_dly   = {m_dly[0], btn};
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [15:0] data;
      logic        wd;
      logic [15:0] exp0;
      logic [15:0] exp1;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int n, m, events;
      logic prev;
      logic [15:0] dat;
      logic r, w, wd, b;
      logic [1:0] a;

      vecs[0] = '{1'b1, 2'd0, 16'h0001, 1'b0, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h0002, 16'h0101};
      vecs[2] = '{1'b1, 2'd0, 16'h8000, 1'b0, 16'h0006, 16'h0102};
      vecs[3] = '{1'b1, 2'd0, 16'h0002, 1'b1, 16'h0006, 16'h0103};
      vecs[4] = '{1'b1, 2'd0, 16'h7FF4, 1'b0, 16'h0002, 16'h0103};
      vecs[5] = '{1'b1, 2'd1, 16'hFFFF, 1'b0, 16'h0002, 16'h0100};
      vecs[6] = '{1'b1, 2'd2, 16'hFFFF, 1'b0, 16'h0002, 16'h0100};
      vecs[7] = '{1'b1, 2'd3, 16'h800F, 1'b0, 16'h0002, 16'h0100};
      vecs[8] = '{1'b1, 2'd0, 16'h000F, 1'b0, 16'h0000, 16'h0100};

      i_rst     = 1'b1;
      i_memAddr = 2'd0;
      i_extBtn  = 1'b0;
      idle();

      // power-on release
      do_reset();
      check("por_rstn0", 16'(o_sysRstn), 16'h0000);
      count_low(n);
      check("por_low_cycles", 16'(n), 16'(H));
      chk_rd("por_cause", 2'd0, 16'h0001);
      chk_rd("por_count", 2'd1, 16'h0000);

      // watchdog pulse in RUN
      i_wdReset = 1'b1;
      @(negedge i_clk);
      i_wdReset = 1'b0;
      count_low(n);
      check("wdt_low_cycles", 16'(n), 16'(H));
      chk_rd("wdt_cause", 2'd0, 16'h0003);
      chk_rd("wdt_count", 2'd1, 16'h0001);

      // software reset then W1C of everything
      write(2'd0, 16'h8000);
      check("sw_hold_next", 16'(o_sysRstn), 16'h0000);
      chk_rd("sw_cause", 2'd0, 16'h0007);
      write(2'd0, 16'h000F);
      chk_rd("sw_w1c_all", 2'd0, 16'h0000);
      count_low(n);
      check("sw_low_rest", 16'(n), 16'(H - 1));

      // retrigger at hold cycle 10 with simultaneous WDT clear
      write(2'd1, 16'h0000);
      i_wdReset = 1'b1;
      @(negedge i_clk);
      i_wdReset = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (o_sysRstn == 1'b0) n++;
         @(negedge i_clk);
      end
      if (o_sysRstn == 1'b0) n++;
      i_wdReset   = 1'b1;
      i_memAddr   = 2'd0;
      i_memDataIn = 16'h0002;
      i_memWrEn   = 1'b1;
      @(negedge i_clk);
      idle();
      count_low(m);
      check("restart_low_total", 16'(n + m), 16'(11 + H));
      chk_rd("restart_count", 2'd1, 16'h0002);
      chk_rd("restart_wdt_sticky", 2'd0, 16'h0002);

      // button glitches then a long press
      write(2'd1, 16'h0000);
      write(2'd0, 16'h000F);
      events = 0;
      prev   = o_sysRstn;
      for (int g = 0; g < 90; g++) begin
         if (g < 30) i_extBtn = ((g % 10) < 5);
         else        i_extBtn = (g < 70);
         @(negedge i_clk);
         if (prev == 1'b1 && o_sysRstn == 1'b0) events++;
         prev = o_sysRstn;
      end
      check("btn_events", 16'(events), 16'h0001);
      check("btn_run_after", 16'(o_sysRstn), 16'h0001);
      chk_rd("btn_count", 2'd1, 16'h0001);
      chk_rd("btn_cause", 2'd0, 16'h0008);

      // COUNT saturation and clear
      write(2'd1, 16'h0000);
      i_wdReset = 1'b1;
      for (int k = 0; k < 256; k++) @(negedge i_clk);
      i_wdReset = 1'b0;
      chk_rd("sat_count", 2'd1, 16'h01FF);
      write(2'd1, 16'h1234);
      chk_rd("sat_clear", 2'd1, 16'h0100);

      // vector table from a clean reset
      do_reset();
      count_low(n);
      check("tbl_por_low", 16'(n), 16'(H));
      for (int i = 0; i < 9; i++) begin
         i_memWrEn   = vecs[i].wr;
         i_memAddr   = vecs[i].addr;
         i_memDataIn = vecs[i].data;
         i_wdReset   = vecs[i].wd;
         @(negedge i_clk);
         idle();
         chk_rd($sformatf("tbl%0d_cause", i), 2'd0, vecs[i].exp0);
         chk_rd($sformatf("tbl%0d_count", i), 2'd1, vecs[i].exp1);
         chk_rd($sformatf("tbl%0d_addr2", i), 2'd2, 16'h0000);
      end

      // randomized traffic against the model
      m_reset();
      b = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge i_clk);
         r  = (k == 0) || ($urandom_range(0, 599) == 0);
         wd = ($urandom_range(0, 29) == 0);
         w  = ($urandom_range(0, 5) == 0);
         a  = 2'($urandom_range(0, 3));
         dat = 16'($urandom);
         dat[15] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 14) == 0) b = ~b;
         i_rst = r; i_wdReset = wd; i_memWrEn = w; i_memAddr = a;
         i_memDataIn = dat; i_extBtn = b;
         #1;
         if (k > 0) begin
            check("rnd_rstn", 16'(o_sysRstn), 16'(m_low == 0));
            check("rnd_read", o_memDataOut, m_read(a));
         end
         @(posedge i_clk);
         m_step(r, w, a, dat, wd, b);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
